// File: rtl/regfile_mp.sv
// Multi-port register file: two combinational read ports with write forwarding, one write port,
// an aliased auto-incrementing program counter and an NZCV status register.
module regfile_mp #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       NUM_REGS = 16,
    parameter int unsigned       ADDR_W   = 4,
    parameter int unsigned       PC_IDX   = 15,
    parameter int unsigned       PC_STEP  = 4,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pc_inc,
    output logic [DATA_W-1:0] pc_out,
    input  logic              flags_we,
    input  logic [3:0]        flags_in,
    output logic [DATA_W-1:0] cpsr_out
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [3:0]        flags_q;
    logic [3:0]        flags_d;
    logic              pc_wr;

    assign pc_wr = we && (wr_addr == ADDR_W'(PC_IDX));

    // Matching against every in-range index means out-of-range writes simply hit nothing.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (we && (wr_addr == ADDR_W'(i))) begin
                regs_d[i] = wr_data;
            end
        end
        if (pc_inc && !pc_wr) begin
            regs_d[IDX_W'(PC_IDX)] = regs_q[IDX_W'(PC_IDX)] + DATA_W'(PC_STEP);
        end
    end

    always_comb begin
        flags_d = flags_q;
        if (flags_we) begin
            flags_d = flags_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == PC_IDX) ? RESET_PC : '0;
            end
            flags_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            flags_q <= flags_d;
        end
    end

    // Reads default to zero; only an in-range address selects storage or the forwarded write.
    always_comb begin
        ra_data = '0;
        rb_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (ra_addr == ADDR_W'(i)) begin
                ra_data = (we && (wr_addr == ra_addr)) ? wr_data : regs_q[i];
            end
            if (rb_addr == ADDR_W'(i)) begin
                rb_data = (we && (wr_addr == rb_addr)) ? wr_data : regs_q[i];
            end
        end
    end

    assign pc_out   = regs_q[IDX_W'(PC_IDX)];
    assign cpsr_out = {flags_q, {(DATA_W-4){1'b0}}};

endmodule
